// File: rtl/fpu_mul_arbiter_if.sv
// Bus bundle between the FPU issue logic, the shared multiplier arbiter and
// the multiplier datapath. The arbiter takes the master view.
interface fpu_mul_arbiter_if #(
   parameter int X     = 32,
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ*X-1:0] req_a;
   logic [N_REQ*X-1:0] req_b;
   logic               flush;
   logic               mul_start;
   logic [X-1:0]       mul_a;
   logic [X-1:0]       mul_b;
   logic [X-1:0]       mul_out;
   logic [N_REQ-1:0]   resp_valid;
   logic [X-1:0]       resp_data;
   logic               busy;

   modport master (
      input  req_valid, req_a, req_b, flush, mul_out,
      output req_ready, mul_start, mul_a, mul_b, resp_valid, resp_data, busy
   );

   modport slave (
      output req_valid, req_a, req_b, flush, mul_out,
      input  req_ready, mul_start, mul_a, mul_b, resp_valid, resp_data, busy
   );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiplier between N_REQ requesters.
// Define FPU_MUL_ARB_PERF_EN to add saturating issue/stall performance counters.
module fpu_mul_arbiter #(
   parameter int X       = 32,
   parameter int N_REQ   = 2,
   parameter int MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   fpu_mul_arbiter_if.master bus
`ifdef FPU_MUL_ARB_PERF_EN
   ,
   output logic [31:0]      perf_issue_cnt,
   output logic [31:0]      perf_stall_cnt
`endif
);

   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   win_id;
   logic             win_found;
   logic             grant;
   logic [N_REQ-1:0] grant_oh;

   logic             mul_start_q;
   logic [IDW-1:0]   start_id_q;
   logic [X-1:0]     mul_a_q, mul_b_q;

   logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [IDW-1:0]     tag_id_q [MUL_LAT];
   logic               busy_d;

   logic [N_REQ-1:0] resp_valid_q;
   logic [X-1:0]     resp_data_q;

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return IDW'(sum);
   endfunction

   // Search starts at the pointer so the last winner has lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && bus.req_valid[wrap_add(rr_q, i)]) begin
            win_found = 1'b1;
            win_id    = wrap_add(rr_q, i);
         end
      end
   end

   assign grant = win_found && rst_n && !bus.flush && (state_q != ST_FLUSH);

   always_comb begin
      grant_oh = '0;
      if (grant) grant_oh[win_id] = 1'b1;
   end

   assign rr_d = grant ? wrap_add(win_id, 1) : rr_q;

   always_comb begin
      tag_vld_d[0] = mul_start_q;
      for (int k = 1; k < MUL_LAT; k++) tag_vld_d[k] = tag_vld_q[k-1];
   end

   assign busy_d = grant | (|tag_vld_d);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (grant)   state_d = ST_RUN;
         ST_RUN:   if (!busy_d) state_d = ST_IDLE;
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (bus.flush) state_d = ST_FLUSH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_q         <= '0;
         mul_start_q  <= 1'b0;
         start_id_q   <= '0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         tag_vld_q    <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         if (grant) begin
            start_id_q <= win_id;
            mul_a_q    <= bus.req_a[win_id*X +: X];
            mul_b_q    <= bus.req_b[win_id*X +: X];
         end
         if (bus.flush) begin
            mul_start_q  <= 1'b0;
            tag_vld_q    <= '0;
            resp_valid_q <= '0;
         end else begin
            mul_start_q  <= grant;
            tag_vld_q    <= tag_vld_d;
            resp_valid_q <= '0;
            // Oldest tag lines up with the cycle mul_out carries its result.
            if (tag_vld_q[MUL_LAT-1]) begin
               resp_valid_q[tag_id_q[MUL_LAT-1]] <= 1'b1;
               resp_data_q                       <= bus.mul_out;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_tag
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               tag_id_q[gi] <= '0;
            else if (gi == 0)
               tag_id_q[gi] <= start_id_q;
            else
               tag_id_q[gi] <= tag_id_q[(gi > 0) ? gi-1 : 0];
         end
      end
   endgenerate

   assign bus.req_ready  = grant_oh;
   assign bus.mul_start  = mul_start_q;
   assign bus.mul_a      = mul_a_q;
   assign bus.mul_b      = mul_b_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.busy       = mul_start_q | (|tag_vld_q);

`ifdef FPU_MUL_ARB_PERF_EN
   logic [31:0] issue_cnt_q;
   logic [31:0] stall_cnt_q;
   logic        stall;

   // A stall is any requester presenting valid without being accepted.
   assign stall = |(bus.req_valid & ~grant_oh);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else if (bus.flush) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (mul_start_q && (issue_cnt_q != 32'hFFFF_FFFF)) issue_cnt_q <= issue_cnt_q + 32'd1;
         if (stall && (stall_cnt_q != 32'hFFFF_FFFF))       stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_issue_cnt = issue_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter: reset, single op, special operands,
// back-to-back round robin, flush, async reset and (optionally) perf counters.
module tb_fpu_mul_arbiter;
   localparam int X       = 32;
   localparam int N_REQ   = 2;
   localparam int MUL_LAT = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fpu_mul_arbiter_if #(.X(X), .N_REQ(N_REQ)) bus ();

`ifdef FPU_MUL_ARB_PERF_EN
   logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

   fpu_mul_arbiter #(.X(X), .N_REQ(N_REQ), .MUL_LAT(MUL_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef FPU_MUL_ARB_PERF_EN
      ,
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   // Multiplier stand-in: known products for the directed cases, a fixed mix otherwise.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4000_0000;
      if (a == 32'h7F80_0000 && b == 32'h0000_0000) return 32'h7FC0_0000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
   endfunction

   logic [31:0] mpipe [MUL_LAT];
   always @(posedge clk) begin
      mpipe[0] <= bus.mul_start ? fmul(bus.mul_a, bus.mul_b) : 32'hDEAD_BEEF;
      for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
   end
   assign bus.mul_out = mpipe[MUL_LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.flush = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_a = '0;
      bus.req_b = '0;
      tick();
      tick();
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", bus.req_ready); end
      checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got %b exp 0", bus.mul_start); end
      checks++; if (bus.mul_a !== 32'h0 || bus.mul_b !== 32'h0) begin errors++; $display("FAIL reset_mul_ab got %h/%h exp 0/0", bus.mul_a, bus.mul_b); end
      checks++; if (bus.resp_valid !== 2'b00 || bus.resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp got %b/%h exp 00/0", bus.resp_valid, bus.resp_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      bus.req_valid = 2'b00;
      #2 rst_n = 1'b1;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_single();
      tick();
      bus.req_valid = 2'b01;
      bus.req_a = {32'h0, 32'h3F80_0000};
      bus.req_b = {32'h0, 32'h4000_0000};
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      checks++; if (bus.mul_start !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", bus.mul_start); end
      checks++; if (bus.mul_a !== 32'h3F80_0000 || bus.mul_b !== 32'h4000_0000) begin errors++; $display("FAIL single_ops got %h/%h exp 3f800000/40000000", bus.mul_a, bus.mul_b); end
      for (int k = 0; k < MUL_LAT; k++) begin
         tick();
         checks++; if (bus.resp_valid !== 2'b00 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_wait%0d got rv=%b busy=%b exp rv=00 busy=1", k, bus.resp_valid, bus.busy); end
      end
      tick();
      checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'h4000_0000) begin errors++; $display("FAIL single_resp got %b/%h exp 01/40000000", bus.resp_valid, bus.resp_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b exp 0", bus.busy); end
      tick();
      checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL single_resp_pulse got %b exp 00", bus.resp_valid); end
      $display("test_single done");
   endtask

   task automatic test_special();
      tick();
      bus.req_valid = 2'b10;
      bus.req_a = {32'h7F80_0000, 32'h0};
      bus.req_b = {32'h0000_0000, 32'h0};
      #1;
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL special_ready got %b exp 10", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      for (int k = 0; k < MUL_LAT; k++) tick();
      tick();
      checks++; if (bus.resp_valid !== 2'b10) begin errors++; $display("FAIL special_rv got %b exp 10", bus.resp_valid); end
      checks++; if (bus.resp_data[30:23] !== 8'hFF || bus.resp_data[22] !== 1'b1) begin errors++; $display("FAIL special_nan got %h exp exponent ff mant msb 1", bus.resp_data); end
      checks++; if (bus.resp_data !== 32'h7FC0_0000) begin errors++; $display("FAIL special_data got %h exp 7fc00000", bus.resp_data); end
      tick();
      $display("test_special done");
   endtask

   task automatic test_back_to_back();
      int g;
      logic [31:0] ea, eb;
      logic [1:0]  eoh;
      for (int c = 0; c <= MUL_LAT + 10; c++) begin
         tick();
         if (c < 8) begin
            bus.req_valid = 2'b11;
            bus.req_a = {32'h2000_0000 + c, 32'h1000_0000 + c};
            bus.req_b = {32'h0200_0000 + c, 32'h0100_0000 + c};
         end else begin
            bus.req_valid = 2'b00;
         end
         #1;
         if (c < 8) begin
            eoh = (c % 2 == 1) ? 2'b10 : 2'b01;
            checks++; if (bus.req_ready !== eoh) begin errors++; $display("FAIL b2b_grant%0d got %b exp %b", c, bus.req_ready, eoh); end
         end
         checks++; if (bus.mul_start !== ((c >= 1 && c <= 8) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL b2b_start%0d got %b exp %b", c, bus.mul_start, (c >= 1 && c <= 8)); end
         if (c >= MUL_LAT + 2 && c < MUL_LAT + 10) begin
            g   = c - MUL_LAT - 2;
            ea  = (g % 2 == 1) ? 32'h2000_0000 + g : 32'h1000_0000 + g;
            eb  = (g % 2 == 1) ? 32'h0200_0000 + g : 32'h0100_0000 + g;
            eoh = (g % 2 == 1) ? 2'b10 : 2'b01;
            checks++; if (bus.resp_valid !== eoh || bus.resp_data !== fmul(ea, eb)) begin errors++; $display("FAIL b2b_resp%0d got %b/%h exp %b/%h", g, bus.resp_valid, bus.resp_data, eoh, fmul(ea, eb)); end
         end else begin
            checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL b2b_idle%0d got %b exp 00", c, bus.resp_valid); end
         end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_flush();
      for (int c = 0; c <= 11; c++) begin
         tick();
         bus.flush = (c == 3);
         case (c)
            0: begin bus.req_valid = 2'b01; bus.req_a = {32'h0, 32'h1111_1111}; bus.req_b = {32'h0, 32'h2222_2222}; end
            1: begin bus.req_valid = 2'b10; bus.req_a = {32'h3333_3333, 32'h0}; bus.req_b = {32'h4444_4444, 32'h0}; end
            3, 4: begin bus.req_valid = 2'b01; bus.req_a = {32'h0, 32'h5555_5555}; bus.req_b = {32'h0, 32'h6666_6666}; end
            5: begin bus.req_valid = 2'b01; bus.req_a = {32'h0, 32'h3F80_0000}; bus.req_b = {32'h0, 32'h4000_0000}; end
            default: bus.req_valid = 2'b00;
         endcase
         #1;
         if (c == 0) begin checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL flush_g0 got %b exp 01", bus.req_ready); end end
         if (c == 1) begin checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL flush_g1 got %b exp 10", bus.req_ready); end end
         if (c == 2) begin checks++; if (bus.mul_start !== 1'b1) begin errors++; $display("FAIL flush_issue2 got %b exp 1", bus.mul_start); end end
         if (c == 3) begin checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL flush_nogrant got %b exp 00", bus.req_ready); end end
         if (c == 4) begin
            checks++; if (bus.busy !== 1'b0 || bus.mul_start !== 1'b0) begin errors++; $display("FAIL flush_busy got busy=%b start=%b exp 0/0", bus.busy, bus.mul_start); end
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL flush_state_ready got %b exp 00", bus.req_ready); end
         end
         if (c == 5) begin checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL flush_regrant got %b exp 01", bus.req_ready); end end
         if (c >= 4 && c <= 9) begin checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL flush_noresp%0d got %b exp 00", c, bus.resp_valid); end end
         if (c == 10) begin checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'h4000_0000) begin errors++; $display("FAIL flush_after got %b/%h exp 01/40000000", bus.resp_valid, bus.resp_data); end end
      end
      bus.flush = 1'b0;
      $display("test_flush done");
   endtask

   task automatic test_async_reset();
      tick();
      bus.req_valid = 2'b01;
      bus.req_a = {32'h0, 32'h0BAD_0001};
      bus.req_b = {32'h0, 32'h0BAD_0002};
      tick();
      bus.req_valid = 2'b11;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (bus.mul_start !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL arst_start got start=%b busy=%b exp 0/0", bus.mul_start, bus.busy); end
      checks++; if (bus.mul_a !== 32'h0 || bus.resp_data !== 32'h0 || bus.resp_valid !== 2'b00) begin errors++; $display("FAIL arst_regs got %h/%h/%b exp 0/0/00", bus.mul_a, bus.resp_data, bus.resp_valid); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL arst_ready got %b exp 00", bus.req_ready); end
      bus.req_valid = 2'b00;
      #2 rst_n = 1'b1;
      tick();
      bus.req_valid = 2'b11;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL arst_tie got %b exp 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      for (int k = 0; k < MUL_LAT + 3; k++) tick();
      $display("test_async_reset done");
   endtask

`ifdef FPU_MUL_ARB_PERF_EN
   task automatic test_perf();
      logic [1:0] pat [5];
      pat[0] = 2'b11; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b10; pat[4] = 2'b11;
      tick();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      #1;
      checks++; if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_issue_cnt, perf_stall_cnt); end
      for (int c = 0; c < 5; c++) begin
         tick();
         bus.req_valid = pat[c];
         bus.req_a = {32'h7000_0000 + c, 32'h6000_0000 + c};
         bus.req_b = {32'h0000_0011, 32'h0000_0022};
      end
      tick();
      bus.req_valid = 2'b00;
      tick();
      checks++; if (perf_issue_cnt !== 32'd5) begin errors++; $display("FAIL perf_issue got %0d exp 5", perf_issue_cnt); end
      checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d exp 3", perf_stall_cnt); end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      checks++; if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_flush got %0d/%0d exp 0/0", perf_issue_cnt, perf_stall_cnt); end
      tick();
      $display("test_perf done");
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_special();
      test_back_to_back();
      test_flush();
      test_async_reset();
`ifdef FPU_MUL_ARB_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
